// File: rtl/seri_par_ctrl.sv
// Serial-to-parallel frame controller: collects WIDTH qualified bits (MSB first)
// into a registered word and holds it under a valid/ready handshake.
module seri_par_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             ck,
  input  logic             res,
  input  logic             start,
  input  logic             en,
  input  logic             si,
  input  logic             abort,
  input  logic             ready,
  output logic [WIDTH-1:0] q,
  output logic             valid,
  output logic             busy,
  output logic             ovf
);
  // state | meaning
  // IDLE  | waiting for start
  // SHIFT | collecting qualified serial bits
  // DONE  | q holds a complete frame awaiting ready
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [WIDTH-1:0] sr, sr_nx, q_nx, shifted;
  logic             ovf_nx;

  assign shifted = {sr[WIDTH-2:0], si};

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    sr_nx    = sr;
    q_nx     = q;
    ovf_nx   = ovf;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = SHIFT;
          cnt_nx   = '0;
          sr_nx    = '0;
        end
      end
      SHIFT: begin
        // abort wins over a qualified bit, even the last one
        if (abort) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (en) begin
          sr_nx = shifted;
          if (cnt == LAST) begin
            q_nx     = shifted;
            state_nx = DONE;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + 1'b1;
          end
        end
      end
      DONE: begin
        if (ready) begin
          if (start) begin
            state_nx = SHIFT;
            cnt_nx   = '0;
            sr_nx    = '0;
          end else begin
            state_nx = IDLE;
          end
        end else if (start) begin
          ovf_nx = 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // busy/valid are registered from the next state so outputs never decode glitches
  always_ff @(posedge ck or negedge res) begin
    if (!res) begin
      state <= IDLE;
      cnt   <= '0;
      sr    <= '0;
      q     <= '0;
      ovf   <= 1'b0;
      valid <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      sr    <= sr_nx;
      q     <= q_nx;
      ovf   <= ovf_nx;
      valid <= (state_nx == DONE);
      busy  <= (state_nx == SHIFT);
    end
  end

endmodule

// File: doc/seri_par_ctrl.md
SERI_PAR_CTRL -- requirements
Module: seri_par_ctrl

Interface
REQ-001 Parameter WIDTH, default 4: serial frame length in bits and parallel word width; legal range 2..16.
REQ-002 ck  input  1  single clock; all state updates on rising edge.
REQ-003 res  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  frame start request; sampled only in IDLE, and in DONE when ready=1.
REQ-005 en  input  1  bit-valid qualifier; si is shifted in only on cycles with en=1 in SHIFT.
REQ-006 si  input  1  serial data in, MSB of frame first.
REQ-007 abort  input  1  cancel the frame in progress.
REQ-008 ready  input  1  downstream accepts the word when valid=1 and ready=1.
REQ-009 q  output  WIDTH  assembled parallel word, registered.
REQ-010 valid  output  1  q holds a complete, unaccepted frame.
REQ-011 busy  output  1  high while in SHIFT.
REQ-012 ovf  output  1  sticky overrun flag.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE; busy=1 iff SHIFT, valid=1 iff DONE.
REQ-014 IDLE: start=1 -> SHIFT with bit counter cleared to 0 and shift register cleared; no si sampled on the start cycle.
REQ-015 SHIFT, en=1: shift register becomes {sr[WIDTH-2:0], si}; counter increments by 1.
REQ-016 SHIFT, en=0: shift register and counter hold; no timeout.
REQ-017 SHIFT, en=1 with counter=WIDTH-1: q loads {sr[WIDTH-2:0], si}, FSM -> DONE, so valid rises the edge after the WIDTH-th qualified bit.
REQ-018 SHIFT, abort=1: FSM -> IDLE, counter cleared, q and ovf unchanged; abort SHALL take priority over en on the same cycle, including the final bit.
REQ-019 start in SHIFT SHALL be ignored and SHALL NOT set ovf.
REQ-020 DONE: q and valid held stable until ready=1.
REQ-021 DONE, ready=1, start=0: FSM -> IDLE, valid falls next edge.
REQ-022 DONE, ready=1, start=1: handshake completes and FSM -> SHIFT in the same edge (back-to-back frames, zero idle cycles).
REQ-023 DONE, ready=0, start=1: start dropped, ovf set to 1.
REQ-024 ovf SHALL remain 1 until reset; abort and handshakes do not clear it.
REQ-025 abort in IDLE or DONE SHALL have no effect; en and si outside SHIFT SHALL be ignored.
REQ-026 Counter width SHALL be clog2(WIDTH)+1 bits; it never exceeds WIDTH-1 and never wraps.

Reset
REQ-027 res=0 SHALL immediately (without a clock edge) force FSM=IDLE, counter=0, shift register=0, q=0, valid=0, busy=0, ovf=0.
REQ-028 Reset asserted mid-frame or in DONE SHALL discard the partial/unaccepted frame; first start after res returns to 1 begins a fresh frame.
REQ-029 Outputs SHALL be glitch-free registered values; no combinational path from inputs to outputs.

Verification (WIDTH=4)
REQ-030 Basic frame: start, then en=1 with si=1,0,1,1 on 4 consecutive cycles, ready=1 -> busy high 4 cycles, q=1011 and valid=1 for exactly one cycle.
REQ-031 Gapped bits: si=1,1,0,0 with en=0 inserted between every bit -> q=1100 after the 4th qualified bit only, busy high 7 cycles.
REQ-032 Backpressure/overrun: frame 0110 with ready=0, start pulsed in DONE -> valid and q=0110 held, ovf=1; ready=1 -> valid falls, FSM IDLE, ovf stays 1.
REQ-033 Back-to-back: frame 1001 completes, ready=1 and start=1 in same DONE cycle, next frame 0111 -> second valid with q=0111 exactly 5 cycles after first valid.
REQ-034 Abort: 3 bits shifted, abort=1 together with en=1 -> IDLE, valid never rises, previous q unchanged; a new 4-bit frame 1010 then completes normally.
REQ-035 Async reset: res pulsed low between clock edges during bit 2 -> all outputs 0 before next edge; a subsequent frame 0011 yields q=0011.
